// File: rtl/bioee_adc_framer.sv
// bioee_adc_framer: registers each 12-bit ADC conversion and optionally averages
// 2^n conversions into one sample. Each frame starts with a numbered header word,
// and the block emits 16-bit words to the ADC FIFO on adc_clk. A word that meets a
// full FIFO is dropped and counted in drop_count.
//
// Write handshake: the block samples fifo_full on the clock edge that registers a
// word. A data word with fifo_full=0 on that edge appears on dataout with a one-cycle
// write_en pulse in the following cycle. A data word with fifo_full=1 on that edge is
// dropped and never retried. A header word waits in HEADER until fifo_full=0.
// dataout keeps its last value while write_en=0.
module bioee_adc_framer #(
  parameter int FRAME_LEN    = 1024,
  parameter int AVG_LOG2_MAX = 4
) (
  input  logic        adc_clk,
  input  logic        adc_resetn,
  input  logic [11:0] adc_data,
  input  logic        adc_otr,
  input  logic        capture_en,
  input  logic [2:0]  avg_log2,
  input  logic        fifo_full,
  output logic [15:0] dataout,
  output logic        write_en,
  output logic [15:0] drop_count,
  output logic        otr_sticky,
  output logic        busy
);

  localparam logic [1:0]  ST_IDLE   = 2'd0;
  localparam logic [1:0]  ST_HEADER = 2'd1;
  localparam logic [1:0]  ST_DATA   = 2'd2;
  localparam logic [2:0]  AVG_MAX   = 3'(AVG_LOG2_MAX);
  localparam logic [15:0] SLOT_LAST = 16'(FRAME_LEN - 1);

  // FSM state; a checker can read it hierarchically as <inst>.state
  logic [1:0]  state;
  logic [11:0] s1_data;
  logic        s1_otr;
  logic [2:0]  n_q;
  logic [15:0] acc;
  logic        win_otr;
  logic [7:0]  win_cnt;
  logic [15:0] slot_cnt;
  logic [14:0] frame_num;

  logic [15:0] acc_sum;
  logic        otr_sum;
  logic [7:0]  win_last;
  logic        win_done;
  logic [11:0] avg_bits;
  logic [15:0] data_word;
  logic [2:0]  n_clamp;

  // Input stage S1: every downstream decision uses these registered values
  always_ff @(posedge adc_clk or negedge adc_resetn) begin
    if (!adc_resetn) begin
      s1_data <= 12'd0;
      s1_otr  <= 1'b0;
    end else begin
      s1_data <= adc_data;
      s1_otr  <= adc_otr;
    end
  end

  // Window arithmetic: running sum including this cycle's sample, and the averaged word
  always_comb begin
    acc_sum   = acc + {4'd0, s1_data};
    otr_sum   = win_otr | s1_otr;
    win_last  = 8'((9'd1 << n_q) - 9'd1);
    win_done  = (win_cnt == win_last);
    avg_bits  = 12'(acc_sum >> n_q);
    data_word = {1'b0, otr_sum, 2'b00, avg_bits};
    n_clamp   = (avg_log2 > AVG_MAX) ? AVG_MAX : avg_log2;
  end

  // Framing FSM: header/data sequencing, window accumulation, FIFO writes and drop counting
  always_ff @(posedge adc_clk or negedge adc_resetn) begin
    if (!adc_resetn) begin
      state      <= ST_IDLE;
      n_q        <= 3'd0;
      acc        <= 16'd0;
      win_otr    <= 1'b0;
      win_cnt    <= 8'd0;
      slot_cnt   <= 16'd0;
      frame_num  <= 15'd0;
      dataout    <= 16'd0;
      write_en   <= 1'b0;
      drop_count <= 16'd0;
    end else begin
      write_en <= 1'b0;
      if (!capture_en) begin
        // Leaving capture abandons any partial window or frame; nothing is flushed
        state    <= ST_IDLE;
        acc      <= 16'd0;
        win_otr  <= 1'b0;
        win_cnt  <= 8'd0;
        slot_cnt <= 16'd0;
      end else begin
        case (state)
          ST_IDLE: begin
            acc      <= 16'd0;
            win_otr  <= 1'b0;
            win_cnt  <= 8'd0;
            slot_cnt <= 16'd0;
            state    <= ST_HEADER;
          end
          ST_HEADER: begin
            // n holds for the whole frame; S1 samples seen here are discarded
            n_q <= n_clamp;
            if (!fifo_full) begin
              write_en  <= 1'b1;
              dataout   <= {1'b1, frame_num};
              frame_num <= frame_num + 15'd1;
              state     <= ST_DATA;
            end
          end
          ST_DATA: begin
            if (win_done) begin
              acc     <= 16'd0;
              win_otr <= 1'b0;
              win_cnt <= 8'd0;
              if (!fifo_full) begin
                write_en <= 1'b1;
                dataout  <= data_word;
              end else if (drop_count != 16'hFFFF) begin
                drop_count <= drop_count + 16'd1;
              end
              // The slot is consumed whether or not the word reached the FIFO
              if (slot_cnt == SLOT_LAST) begin
                slot_cnt <= 16'd0;
                state    <= ST_HEADER;
              end else begin
                slot_cnt <= slot_cnt + 16'd1;
              end
            end else begin
              acc     <= acc_sum;
              win_otr <= otr_sum;
              win_cnt <= win_cnt + 8'd1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Out-of-range flag for any conversion taken into a window; only reset clears it
  always_ff @(posedge adc_clk or negedge adc_resetn) begin
    if (!adc_resetn) begin
      otr_sticky <= 1'b0;
    end else if (state == ST_DATA && s1_otr) begin
      otr_sticky <= 1'b1;
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_bioee_adc_framer.sv
// Testbench for bioee_adc_framer. It applies a per-cycle vector table, then
// hand-written multi-cycle sequences, then randomized traffic. A behavioural
// model and a scoreboard check the DUT every cycle.
module tb_bioee_adc_framer;

  localparam int FRAME_LEN = 4;
  localparam int AVG_MAX   = 4;

  // ---------------- clock / reset / DUT ----------------
  logic        adc_clk = 1'b0;
  logic        adc_resetn = 1'b0;
  logic [11:0] adc_data = 12'd0;
  logic        adc_otr = 1'b0;
  logic        capture_en = 1'b0;
  logic [2:0]  avg_log2 = 3'd0;
  logic        fifo_full = 1'b0;
  logic [15:0] dataout;
  logic        write_en;
  logic [15:0] drop_count;
  logic        otr_sticky;
  logic        busy;

  always #5 adc_clk = ~adc_clk;

  bioee_adc_framer #(.FRAME_LEN(FRAME_LEN), .AVG_LOG2_MAX(AVG_MAX)) dut (
    .adc_clk    (adc_clk),
    .adc_resetn (adc_resetn),
    .adc_data   (adc_data),
    .adc_otr    (adc_otr),
    .capture_en (capture_en),
    .avg_log2   (avg_log2),
    .fifo_full  (fifo_full),
    .dataout    (dataout),
    .write_en   (write_en),
    .drop_count (drop_count),
    .otr_sticky (otr_sticky),
    .busy       (busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1 waiting to write header, 2 collecting samples
  int          m_phase, m_n, m_slot, m_frame, m_drop;
  int          m_s1_data;
  bit          m_s1_otr;
  bit          m_we, m_sticky;
  logic [15:0] m_last;
  int          win_d[$];
  bit          win_o[$];
  logic [15:0] exp_q[$];

  task automatic model_reset();
    m_phase = 0; m_n = 0; m_slot = 0; m_frame = 0; m_drop = 0;
    m_s1_data = 0; m_s1_otr = 0; m_we = 0; m_sticky = 0; m_last = 16'h0000;
    win_d.delete(); win_o.delete(); exp_q.delete();
  endtask

  task automatic model_step();
    int          sum;
    bit          any_otr;
    logic [15:0] word;
    m_we = 0;
    if (m_phase == 2 && m_s1_otr) m_sticky = 1;
    if (!capture_en) begin
      m_phase = 0; m_slot = 0;
      win_d.delete(); win_o.delete();
    end else if (m_phase == 0) begin
      m_phase = 1;
    end else if (m_phase == 1) begin
      m_n = (int'(avg_log2) > AVG_MAX) ? AVG_MAX : int'(avg_log2);
      if (!fifo_full) begin
        word = 16'h8000 | 16'(m_frame);
        m_we = 1; m_last = word; exp_q.push_back(word);
        m_frame = (m_frame + 1) % 32768;
        m_phase = 2;
      end
    end else begin
      win_d.push_back(m_s1_data);
      win_o.push_back(m_s1_otr);
      if (win_d.size() == (1 << m_n)) begin
        sum = 0; any_otr = 0;
        foreach (win_d[i]) begin
          sum += win_d[i];
          any_otr |= win_o[i];
        end
        word = {1'b0, any_otr, 2'b00, 12'(sum >> m_n)};
        win_d.delete(); win_o.delete();
        if (!fifo_full) begin
          m_we = 1; m_last = word; exp_q.push_back(word);
        end else if (m_drop < 65535) begin
          m_drop++;
        end
        m_slot++;
        if (m_slot == FRAME_LEN) begin
          m_slot = 0; m_phase = 1;
        end
      end
    end
    m_s1_data = int'(adc_data);
    m_s1_otr  = adc_otr;
  endtask

  initial forever begin
    @(posedge adc_clk or negedge adc_resetn);
    if (!adc_resetn) model_reset();
    else model_step();
  end

  // ---------------- scoreboard (sampled on falling edge) ----------------
  initial forever begin
    logic [15:0] exp_word;
    @(negedge adc_clk);
    chk("model_we", write_en, m_we);
    if (m_we && exp_q.size() > 0) begin
      exp_word = exp_q.pop_front();
      chk("model_word", dataout, exp_word);
    end else begin
      chk("model_hold", dataout, m_last);
    end
    chk("model_drop", drop_count, 16'(m_drop));
    chk("model_sticky", otr_sticky, m_sticky);
    chk("model_busy", busy, m_phase != 0);
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    adc_resetn = 1'b0; capture_en = 1'b0; fifo_full = 1'b0;
    adc_data = 12'd0; adc_otr = 1'b0; avg_log2 = 3'd0;
    repeat (3) @(negedge adc_clk);
    adc_resetn = 1'b1;
  endtask

  task automatic next_word(input int budget, output logic [15:0] w, output int dt);
    dt = 0;
    w  = 16'h0000;
    do begin
      @(negedge adc_clk);
      dt++;
    end while (!write_en && dt < budget);
    if (!write_en) begin
      n_cmp++; n_bad++;
      $display("FAIL next_word: no write_en within %0d cycles at %0t", budget, $time);
    end else begin
      w = dataout;
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        cap;
    logic [11:0] data;
    logic        full;
    logic        exp_we;
    logic [15:0] exp_dout;
    logic [15:0] exp_drop;
  } vec_t;

  vec_t vecs[20];

  task automatic set_vec(input int i, input logic full, input logic we,
                         input logic [15:0] dout, input logic [15:0] drop);
    vecs[i].cap      = 1'b1;
    vecs[i].data     = 12'(i);
    vecs[i].full     = full;
    vecs[i].exp_we   = we;
    vecs[i].exp_dout = dout;
    vecs[i].exp_drop = drop;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main test ----------------
  initial begin
    logic [15:0] w, w1, w2, w3, w4;
    int          dt;

    // n=0 ramp with FRAME_LEN=4, then drops spanning a header stall
    set_vec(0,  1'b0, 1'b0, 16'h0000, 16'd0);
    set_vec(1,  1'b0, 1'b1, 16'h8000, 16'd0);
    set_vec(2,  1'b0, 1'b1, 16'h0001, 16'd0);
    set_vec(3,  1'b0, 1'b1, 16'h0002, 16'd0);
    set_vec(4,  1'b0, 1'b1, 16'h0003, 16'd0);
    set_vec(5,  1'b0, 1'b1, 16'h0004, 16'd0);
    set_vec(6,  1'b0, 1'b1, 16'h8001, 16'd0);
    set_vec(7,  1'b0, 1'b1, 16'h0006, 16'd0);
    set_vec(8,  1'b1, 1'b0, 16'h0006, 16'd1);
    set_vec(9,  1'b1, 1'b0, 16'h0006, 16'd2);
    set_vec(10, 1'b1, 1'b0, 16'h0006, 16'd3);
    set_vec(11, 1'b1, 1'b0, 16'h0006, 16'd3);
    set_vec(12, 1'b1, 1'b0, 16'h0006, 16'd3);
    set_vec(13, 1'b1, 1'b0, 16'h0006, 16'd3);
    set_vec(14, 1'b0, 1'b1, 16'h8002, 16'd3);
    set_vec(15, 1'b1, 1'b0, 16'h8002, 16'd4);
    set_vec(16, 1'b1, 1'b0, 16'h8002, 16'd5);
    set_vec(17, 1'b0, 1'b1, 16'h0010, 16'd5);
    set_vec(18, 1'b0, 1'b1, 16'h0011, 16'd5);
    set_vec(19, 1'b0, 1'b1, 16'h8003, 16'd5);

    do_reset();
    chk("rst_dataout", dataout, 16'h0000);
    chk("rst_we", write_en, 1'b0);
    chk("rst_drop", drop_count, 16'd0);
    chk("rst_sticky", otr_sticky, 1'b0);
    chk("rst_busy", busy, 1'b0);

    foreach (vecs[i]) begin
      capture_en = vecs[i].cap;
      adc_data   = vecs[i].data;
      fifo_full  = vecs[i].full;
      @(negedge adc_clk);
      chk($sformatf("vec%0d_we", i), write_en, vecs[i].exp_we);
      chk($sformatf("vec%0d_dout", i), dataout, vecs[i].exp_dout);
      chk($sformatf("vec%0d_drop", i), drop_count, vecs[i].exp_drop);
      chk($sformatf("vec%0d_busy", i), busy, 1'b1);
    end

    // n=2 averaging: constant 0xABC with one 0xABF in the second window
    do_reset();
    avg_log2 = 3'd2; adc_data = 12'hABC; capture_en = 1'b1;
    next_word(10, w, dt);
    chk("avg_hdr", w, 16'h8000);
    next_word(10, w, dt);
    chk("avg_gap1", dt, 4);
    chk("avg_word1", w, 16'h0ABC);
    adc_data = 12'hABF;
    @(negedge adc_clk);
    adc_data = 12'hABC;
    next_word(10, w, dt);
    chk("avg_gap2", dt + 1, 4);
    chk("avg_word2", w, 16'h0ABC);

    // n=1: out-of-range pulse on one conversion of the third window
    do_reset();
    avg_log2 = 3'd1; adc_data = 12'h100; capture_en = 1'b1;
    next_word(10, w, dt);
    chk("otr_hdr", w, 16'h8000);
    next_word(10, w1, dt);
    next_word(10, w2, dt);
    chk("otr_sticky_before", otr_sticky, 1'b0);
    adc_otr = 1'b1;
    @(negedge adc_clk);
    adc_otr = 1'b0;
    next_word(10, w3, dt);
    chk("otr_gap3", dt + 1, 2);
    next_word(10, w4, dt);
    chk("otr_word1", w1, 16'h0100);
    chk("otr_word2", w2, 16'h0100);
    chk("otr_word3", w3, 16'h4100);
    chk("otr_word4", w4, 16'h0100);
    chk("otr_sticky_set", otr_sticky, 1'b1);
    next_word(10, w, dt);
    chk("otr_hdr2", w, 16'h8001);
    chk("otr_sticky_held", otr_sticky, 1'b1);

    // capture_en falls on the edge that would complete the window
    @(negedge adc_clk);
    capture_en = 1'b0;
    repeat (4) begin
      @(negedge adc_clk);
      chk("abort_we", write_en, 1'b0);
    end
    chk("abort_busy", busy, 1'b0);
    capture_en = 1'b1;
    next_word(10, w, dt);
    chk("abort_hdr", w, 16'h8002);
    chk("abort_hdr_dt", dt, 2);

    // asynchronous reset mid-frame
    fifo_full = 1'b1;
    repeat (4) @(negedge adc_clk);
    fifo_full = 1'b0;
    @(negedge adc_clk);
    #2 adc_resetn = 1'b0;
    #1;
    chk("arst_dataout", dataout, 16'h0000);
    chk("arst_we", write_en, 1'b0);
    chk("arst_drop", drop_count, 16'd0);
    chk("arst_sticky", otr_sticky, 1'b0);
    chk("arst_busy", busy, 1'b0);
    repeat (2) @(negedge adc_clk);
    avg_log2 = 3'd0;
    adc_resetn = 1'b1;
    next_word(10, w, dt);
    chk("arst_hdr", w, 16'h8000);

    // randomized traffic against the model
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      capture_en = ($urandom_range(0, 99) < 97);
      fifo_full  = ($urandom_range(0, 99) < 15);
      adc_data   = 12'($urandom_range(0, 4095));
      adc_otr    = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 9) == 0) avg_log2 = 3'($urandom_range(0, 7));
      @(negedge adc_clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
